pe_id_config_scheduler: RTL
===========================

Name: pe_id_config_scheduler

Overview:
- Sequencer that programs the PE-array multicast ID tags (filter/ifmap/ipsum/opsum X and Y IDs plus LN_config) into the array's NoC controllers over a serial valid/ready config bus.
- Sits between the combinational ID generator and the GLB-to-PE buses.
- Snapshots all generator outputs on start, then emits one ID per handshake in fixed order, and pulses done at the end.

Parameters:
- NUM_ROWS, 6, PE array rows (Y buses per data type)
- NUM_COLS, 8, PE array columns
- XID_W, 5, X-ID width; all-ones means disabled
- YID_W, 3, Y-ID width; all-ones means disabled

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin programming; single-cycle pulse, level tolerated
- filter_xid_flat / ifmap_xid_flat / ipsum_xid_flat / opsum_xid_flat  in  NUM_ROWS*NUM_COLS*XID_W each  PE idx i at bits [i*XID_W +: XID_W]
- filter_yid_flat / ifmap_yid_flat / ipsum_yid_flat / opsum_yid_flat  in  NUM_ROWS*YID_W each  row r at [r*YID_W +: YID_W]
- ln_config_in  in  5  LN_config from generator
- cfg_valid  out  1  config word valid
- cfg_ready  in  1  receiver accepts
- cfg_tag  out  4  0=LN, 1/2=filter Y/X, 3/4=ifmap Y/X, 5/6=ipsum Y/X, 7/8=opsum Y/X
- cfg_addr  out  6  row (Y tags) or PE idx (X tags); 0 for LN
- cfg_data  out  5  ID value, zero-extended for Y and LN
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final handshake

Behaviour:
- Reset: state IDLE; cfg_valid, busy, done = 0; cfg_tag, cfg_addr, cfg_data = 0; snapshot registers = 0.
- States: IDLE, LN, SCAN, DONE.
- IDLE: when start=1, register all ID inputs and ln_config_in at that edge, set busy=1, go to LN. cfg_valid=1 from the next cycle. Input changes after that edge have no effect.
- LN: present tag 0, addr 0, data=ln_config. On cfg_valid&&cfg_ready go to SCAN with tag=1, addr=0.
- SCAN order:
  - tag 1: addr 0..NUM_ROWS-1
  - tag 2: addr 0..NUM_ROWS*NUM_COLS-1
  - then tags 3..8 in the same pattern (odd tag = Y, even tag = X).
  - Advance only on handshake.
  - On the handshake of tag 8, last addr: go to DONE; cfg_valid drops the next cycle.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. A start in DONE is ignored.
- Handshake rules:
  - While cfg_valid=1 and cfg_ready=0, cfg_tag/addr/data are held stable.
  - cfg_valid never drops before its handshake.
  - The word after a handshake is presented in the next cycle (no bubbles).
- Throughput: with cfg_ready tied high, 1+4*(NUM_ROWS+NUM_ROWS*NUM_COLS) = 217 transfers on 217 consecutive cycles; done is one cycle after the last transfer.
- start while busy: ignored; snapshot unchanged; no restart.
- Async reset mid-operation: immediate return to reset values; no done pulse. The next start restarts from LN.
- cfg_addr counter is sized for NUM_ROWS*NUM_COLS ≤ 64.

Optional Feature:
- Macro CFG_SKIP_DISABLED_EN.
- Defined: in SCAN, entries whose snapshot value is all-ones (31 for X, 7 for Y) are skipped; no transfer is issued for them. Receivers reset their IDs to disabled, so skipping is safe. The skip search evaluates one entry per cycle while cfg_valid=0. Handshaked words are never skipped. LN is always sent. done timing follows the last real transfer, or the end of the search if the last entries are disabled.
- Undefined: every entry is transferred, including disabled values.

Test Plan:
- Reset, cfg_ready=1, start with idx-coded IDs (filter X[i]=i%32) -> 217 transfers in order; first is tag0 data=ln_config_in; tag2 addr 47 data=15; done on cycle 218 after start; busy low with done.
- cfg_ready random 30% duty -> tag/addr/data stable during every stall; sequence identical to the first test; no drops or duplicates.
- Change all inputs and pulse start at transfer 100 -> the remaining words match the original snapshot; no restart; a single done.
- Assert rst_n=0 at transfer 50 -> outputs zero immediately; new start -> sequence begins at tag0 addr0.
- LINEAR-mode pattern (ipsum Y rows 1-5 = 7) with CFG_SKIP_DISABLED_EN -> tag5 sends only addr0 data0; a run with all X entries disabled yields 25 transfers (LN plus the enabled Y entries) and a done pulse.
- start held high across DONE -> exactly one new run begins from IDLE; DONE-cycle start ignored.

Source files
------------

// File: rtl/pe_id_config_scheduler.sv
// Snapshots the PE-array multicast ID tags and streams them over a serial valid/ready config bus.
// Optional build macro CFG_SKIP_DISABLED_EN: skip entries whose snapshot value is all-ones.
module pe_id_config_scheduler #(
  parameter int unsigned NUM_ROWS = 6,
  parameter int unsigned NUM_COLS = 8,
  parameter int unsigned XID_W    = 5,
  parameter int unsigned YID_W    = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] filter_xid_flat,
  input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] ifmap_xid_flat,
  input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] ipsum_xid_flat,
  input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] opsum_xid_flat,
  input  logic [NUM_ROWS*YID_W-1:0]          filter_yid_flat,
  input  logic [NUM_ROWS*YID_W-1:0]          ifmap_yid_flat,
  input  logic [NUM_ROWS*YID_W-1:0]          ipsum_yid_flat,
  input  logic [NUM_ROWS*YID_W-1:0]          opsum_yid_flat,
  input  logic [4:0]                         ln_config_in,
  output logic                               cfg_valid,
  input  logic                               cfg_ready,
  output logic [3:0]                         cfg_tag,
  output logic [5:0]                         cfg_addr,
  output logic [4:0]                         cfg_data,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned NUM_PE = NUM_ROWS * NUM_COLS;
  localparam int unsigned NUM_KIND = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 5;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(8);

  typedef enum logic [1:0] {S_IDLE, S_LN, S_SCAN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic [XID_W-1:0]      snap_x_q [NUM_KIND][NUM_PE];
  logic [YID_W-1:0]      snap_y_q [NUM_KIND][NUM_ROWS];

  logic                  load_c;
  logic                  hs_c, step_c, last_c, final_c, skip_c;
  logic [TAG_W-1:0]      nxt_tag_c;
  logic [ADDR_W-1:0]     nxt_addr_c;
  logic [DATA_W-1:0]     nxt_data_c;
  logic [KIND_W-1:0]     kind_c;
  logic [XID_W-1:0]      x_val_c;
  logic [YID_W-1:0]      y_val_c;

  // Snapshot of all generator outputs, captured only on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KIND; k++) begin
        for (int i = 0; i < NUM_PE; i++) snap_x_q[k][i] <= '0;
        for (int r = 0; r < NUM_ROWS; r++) snap_y_q[k][r] <= '0;
      end
    end else if (load_c) begin
      for (int i = 0; i < NUM_PE; i++) begin
        snap_x_q[0][i] <= filter_xid_flat[i*XID_W +: XID_W];
        snap_x_q[1][i] <= ifmap_xid_flat[i*XID_W +: XID_W];
        snap_x_q[2][i] <= ipsum_xid_flat[i*XID_W +: XID_W];
        snap_x_q[3][i] <= opsum_xid_flat[i*XID_W +: XID_W];
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_y_q[0][r] <= filter_yid_flat[r*YID_W +: YID_W];
        snap_y_q[1][r] <= ifmap_yid_flat[r*YID_W +: YID_W];
        snap_y_q[2][r] <= ipsum_yid_flat[r*YID_W +: YID_W];
        snap_y_q[3][r] <= opsum_yid_flat[r*YID_W +: YID_W];
      end
    end
  end

  // Walk position: tag 0 (LN) behaves as a one-entry tag so it rolls into tag 1 addr 0
  always_comb begin
    hs_c       = valid_q & cfg_ready;
    last_c     = (tag_q == '0) ||
                 (tag_q[0] ? (addr_q == ADDR_W'(NUM_ROWS - 1)) : (addr_q == ADDR_W'(NUM_PE - 1)));
    final_c    = (tag_q == LAST_TAG) && last_c;
    nxt_tag_c  = last_c ? tag_q + TAG_W'(1) : tag_q;
    nxt_addr_c = last_c ? '0 : addr_q + ADDR_W'(1);
    kind_c     = KIND_W'((nxt_tag_c - TAG_W'(1)) >> 1);
    x_val_c    = snap_x_q[kind_c][PE_W'(nxt_addr_c)];
    y_val_c    = snap_y_q[kind_c][ROW_W'(nxt_addr_c)];
    nxt_data_c = nxt_tag_c[0] ? DATA_W'(y_val_c) : DATA_W'(x_val_c);
    // With valid low in SCAN the current entry was found disabled, so move on without a handshake
    step_c     = ((state_q == S_LN) && hs_c) || ((state_q == S_SCAN) && (hs_c || !valid_q));
  end

`ifdef CFG_SKIP_DISABLED_EN
  assign skip_c = nxt_tag_c[0] ? (y_val_c == '1) : (x_val_c == '1);
`else
  assign skip_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LN;
      S_LN:    if (hs_c) state_d = S_SCAN;
      S_SCAN:  if (step_c && final_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus outputs
  always_comb begin
    load_c  = 1'b0;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          tag_d   = '0;
          addr_d  = '0;
          data_d  = ln_config_in;
        end
      end
      S_LN, S_SCAN: begin
        if (step_c) begin
          if (final_c) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tag_d   = '0;
            addr_d  = '0;
            data_d  = '0;
          end else begin
            tag_d   = nxt_tag_c;
            addr_d  = nxt_addr_c;
            data_d  = nxt_data_c;
            valid_d = !skip_c;
          end
        end
      end
      default: ;
    endcase
  end

  assign cfg_valid = valid_q;
  assign cfg_tag   = tag_q;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
